// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: reset PC,
// the NOP returned for faulting fetches, FSM state encoding and the
// fetch-address decode helper.
package imem_responder_pkg;

    // Byte address the fetch stage starts from; default base of word 0.
    localparam logic [31:0] PC_RESET = 32'h0000_1000;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'b00,
        IMEM_WAIT = 2'b01,
        IMEM_RESP = 2'b10
    } imem_state_t;

    // A fetch address maps to RAM when its offset from the base is word
    // aligned and below the RAM depth. The subtraction wraps, so addresses
    // below the base land far out of range.
    function automatic logic imem_addr_valid(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned depth
    );
        logic [31:0] off;
        off = addr - base;
        return (off[1:0] == 2'b00) && ((off >> 2) < depth);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Program RAM: synchronous loader write port and a registered read port.
// A write and a read of the same word on one edge return the new data.
module imem_array #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
    input  logic [31:0]                    wdata,
    input  logic                           re,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Loader write and write-first registered read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory slave on the fetch strobe/ack bus. Each fetch is
// answered after WAIT_STATES extra cycles with one instruction word and a
// single-cycle ack; a changed address restarts the latency so a stale word
// is never acked. Faulting addresses return NOP.
// Optional build macro: IMEM_FAULT_EN adds the o_imem_err fault flag.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,      // power of two
    parameter int unsigned WAIT_STATES = 1,         // 0..15
    parameter logic [31:0] BASE_ADDR   = PC_RESET
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_imem_stb,
    input  logic [31:0]                    i_iaddr,
    output logic [31:0]                    o_inst,
    output logic                           o_imem_ack,
    input  logic                           i_ld_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_ld_addr,
    input  logic [31:0]                    i_ld_data
`ifdef IMEM_FAULT_EN
    ,
    output logic                           o_imem_err
`endif
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);

    imem_state_t   state;
    imem_state_t   state_next;
    logic [3:0]    cnt;
    logic [3:0]    cnt_next;
    logic [31:0]   addr_q;
    logic [31:0]   addr_next;
    logic          enter_resp;
    logic          word_valid;
    logic          fetch_ok;
    logic          ld_we;
    logic [AW-1:0] rd_index;
    logic [31:0]   rd_data;

    // The loader is locked out while reset is held; RAM contents survive.
    assign ld_we = i_ld_we && !rst;

    // Decode is taken from the live address: on every edge that enters
    // RESP, i_iaddr equals the latched address (a mismatch would have
    // redirected instead), and with no wait states nothing is latched yet.
    assign fetch_ok = imem_addr_valid(i_iaddr, BASE_ADDR, DEPTH_WORDS);
    assign rd_index = AW'((i_iaddr - BASE_ADDR) >> 2);

    imem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .we   (ld_we),
        .waddr(i_ld_addr),
        .wdata(i_ld_data),
        .re   (enter_resp && !rst),
        .raddr(rd_index),
        .rdata(rd_data)
    );

    // State, wait counter, latched address and read-validity registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IMEM_IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            word_valid <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            addr_q <= addr_next;
            if (enter_resp) begin
                word_valid <= fetch_ok;
            end
        end
    end

    // Next-state, counter and ack decode.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        addr_next  = addr_q;
        enter_resp = 1'b0;
        o_imem_ack = 1'b0;
        unique case (state)
            IMEM_IDLE: begin
                if (i_imem_stb) begin
                    addr_next = i_iaddr;
                    if (WAIT_STATES == 0) begin
                        state_next = IMEM_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = IMEM_WAIT;
                        cnt_next   = WAIT_LOAD;
                    end
                end
            end
            IMEM_WAIT: begin
                // Abort beats redirect, redirect beats the final count, so
                // a changed address on the last wait cycle restarts as well.
                if (!i_imem_stb) begin
                    state_next = IMEM_IDLE;
                    cnt_next   = '0;
                end else if (i_iaddr != addr_q) begin
                    addr_next = i_iaddr;
                    cnt_next  = WAIT_LOAD;
                end else if (cnt == 4'd1) begin
                    state_next = IMEM_RESP;
                    enter_resp = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            IMEM_RESP: begin
                // A strobe dropped during the response cycle kills the ack.
                o_imem_ack = i_imem_stb;
                state_next = IMEM_IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IMEM_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign o_inst = word_valid ? rd_data : NOP;

`ifdef IMEM_FAULT_EN
    assign o_imem_err = o_imem_ack && !word_valid;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: three instances with 0, 1 and 3 wait
// states share clock, reset and loader bus. Define IMEM_FAULT_EN to build
// and check the fault flag.
module tb_imem_responder;
    import imem_responder_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = PC_RESET;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_we;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    logic        stb0, stb1, stb3;
    logic [31:0] addr0, addr1, addr3;
    logic [31:0] inst0, inst1, inst3;
    logic        ack0, ack1, ack3;
`ifdef IMEM_FAULT_EN
    logic        err0, err1, err3;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [4] = '{32'h0050_0093, 32'h0010_0113, 32'h0020_0193, 32'h0030_0213};
    localparam logic [31:0] WORD5    = 32'h1111_1111;
    localparam logic [31:0] WORD_TOP = 32'h7FF0_0013;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .BASE_ADDR(BASE)) u_ws0 (
        .clk(clk), .rst(rst), .i_imem_stb(stb0), .i_iaddr(addr0), .o_inst(inst0),
        .o_imem_ack(ack0), .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_data(ld_data)
`ifdef IMEM_FAULT_EN
        , .o_imem_err(err0)
`endif
    );

    imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1), .BASE_ADDR(BASE)) u_ws1 (
        .clk(clk), .rst(rst), .i_imem_stb(stb1), .i_iaddr(addr1), .o_inst(inst1),
        .o_imem_ack(ack1), .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_data(ld_data)
`ifdef IMEM_FAULT_EN
        , .o_imem_err(err1)
`endif
    );

    imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3), .BASE_ADDR(BASE)) u_ws3 (
        .clk(clk), .rst(rst), .i_imem_stb(stb3), .i_iaddr(addr3), .o_inst(inst3),
        .o_imem_ack(ack3), .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_data(ld_data)
`ifdef IMEM_FAULT_EN
        , .o_imem_err(err3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [9:0] a, input logic [31:0] d);
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_we   = 1'b0;
    endtask

    // One fetch on the 1-wait-state instance; strobe held through the
    // cycle after the ack, then released.
    task automatic fetch_ws1(input logic [31:0] a, output logic early, output logic ack,
                             output logic [31:0] inst, output logic err, output logic late);
        stb1  = 1'b1;
        addr1 = a;
        tick();
        early = ack1;
        tick();
        ack  = ack1;
        inst = inst1;
`ifdef IMEM_FAULT_EN
        err = err1;
`else
        err = 1'b0;
`endif
        tick();
        late = ack1;
        stb1 = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic        a [3];
        logic [31:0] d [3];
        rst = 1'b1;
        tick();
        tick();
        a = '{ack0, ack1, ack3};
        d = '{inst0, inst1, inst3};
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (a[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_ack[%0d] got=%b exp=0", i, a[i]);
            end
            checks++;
            if (d[i] !== NOP) begin
                errors++;
                $display("FAIL reset_inst[%0d] got=%h exp=%h", i, d[i], NOP);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic load_program();
        for (int i = 0; i < 4; i++) begin
            load_word(10'(i), prog[i]);
        end
        load_word(10'd5, WORD5);
        load_word(10'(DEPTH - 1), WORD_TOP);
    endtask

    task automatic test_ws1_latency();
        stb1  = 1'b1;
        addr1 = BASE;
        tick();
        checks++;
        if (ack1 !== 1'b0) begin
            errors++;
            $display("FAIL ws1_wait_ack got=%b exp=0", ack1);
        end
        tick();
        checks++;
        if (ack1 !== 1'b1) begin
            errors++;
            $display("FAIL ws1_ack got=%b exp=1", ack1);
        end
        checks++;
        if (inst1 !== prog[0]) begin
            errors++;
            $display("FAIL ws1_inst got=%h exp=%h", inst1, prog[0]);
        end
        tick();
        checks++;
        if (ack1 !== 1'b0) begin
            errors++;
            $display("FAIL ws1_ack_width got=%b exp=0", ack1);
        end
        stb1 = 1'b0;
        tick();
    endtask

    task automatic test_ws0_stream();
        stb0  = 1'b1;
        addr0 = BASE;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ack0 !== 1'b1 || inst0 !== prog[i]) begin
                errors++;
                $display("FAIL ws0_stream_ack[%0d] got ack=%b inst=%h exp ack=1 inst=%h",
                         i, ack0, inst0, prog[i]);
            end
            addr0 = BASE + 32'(4 * (i + 1));
            tick();
            checks++;
            if (ack0 !== 1'b0) begin
                errors++;
                $display("FAIL ws0_stream_gap[%0d] got=%b exp=0", i, ack0);
            end
        end
        stb0 = 1'b0;
        tick();
    endtask

    task automatic test_redirect();
        stb3  = 1'b1;
        addr3 = BASE;
        tick();
        tick();
        addr3 = BASE + 32'd8;   // change in the second wait cycle
        checks++;
        if (ack3 !== 1'b0) begin
            errors++;
            $display("FAIL redirect_pre got=%b exp=0", ack3);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (ack3 !== 1'b0) begin
                errors++;
                $display("FAIL redirect_noack[%0d] got=%b exp=0", k, ack3);
            end
        end
        tick();
        checks++;
        if (ack3 !== 1'b1 || inst3 !== prog[2]) begin
            errors++;
            $display("FAIL redirect_ack got ack=%b inst=%h exp ack=1 inst=%h", ack3, inst3, prog[2]);
        end
        stb3 = 1'b0;
        tick();
        checks++;
        if (ack3 !== 1'b0) begin
            errors++;
            $display("FAIL redirect_after got=%b exp=0", ack3);
        end
    endtask

    task automatic test_fault();
        logic [31:0] addrs [4];
        logic [31:0] exp_inst [4];
        logic        exp_err [4];
        logic        early, ack, err, late;
        logic [31:0] inst;
        addrs    = '{BASE + 32'd2, BASE + 32'(4 * DEPTH), 32'h0000_0000, BASE + 32'(4 * (DEPTH - 1))};
        exp_inst = '{NOP, NOP, NOP, WORD_TOP};
        exp_err  = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            fetch_ws1(addrs[i], early, ack, inst, err, late);
            checks++;
            if (early !== 1'b0 || ack !== 1'b1 || late !== 1'b0) begin
                errors++;
                $display("FAIL fault_ack[%0d] got early=%b ack=%b late=%b exp 0 1 0", i, early, ack, late);
            end
            checks++;
            if (inst !== exp_inst[i]) begin
                errors++;
                $display("FAIL fault_inst[%0d] got=%h exp=%h", i, inst, exp_inst[i]);
            end
`ifdef IMEM_FAULT_EN
            checks++;
            if (err !== exp_err[i]) begin
                errors++;
                $display("FAIL fault_err[%0d] got=%b exp=%b", i, err, exp_err[i]);
            end
`endif
        end
    endtask

    task automatic test_forward();
        logic        early, ack, err, late;
        logic [31:0] inst;
        stb1  = 1'b1;
        addr1 = BASE + 32'd4;
        tick();
        ld_we   = 1'b1;
        ld_addr = 10'd1;
        ld_data = 32'hDEAD_BEEF;
        tick();
        ld_we = 1'b0;
        checks++;
        if (ack1 !== 1'b1 || inst1 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL forward got ack=%b inst=%h exp ack=1 inst=deadbeef", ack1, inst1);
        end
        tick();
        stb1 = 1'b0;
        tick();
        fetch_ws1(BASE + 32'd4, early, ack, inst, err, late);
        checks++;
        if (ack !== 1'b1 || inst !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL forward_stored got ack=%b inst=%h exp ack=1 inst=deadbeef", ack, inst);
        end
    endtask

    task automatic test_abort();
        logic seen;
        // Strobe dropped in the response cycle forces ack low at once.
        stb1  = 1'b1;
        addr1 = BASE;
        tick();
        tick();
        stb1 = 1'b0;
        #1;
        checks++;
        if (ack1 !== 1'b0) begin
            errors++;
            $display("FAIL resp_drop got=%b exp=0", ack1);
        end
        tick();

        // Strobe dropped during wait.
        stb3  = 1'b1;
        addr3 = BASE;
        tick();
        tick();
        stb3 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            seen = seen | ack3;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL wait_drop got ack_seen=%b exp=0", seen);
        end

        // Reset during wait, with a loader write that must be ignored.
        stb3  = 1'b1;
        addr3 = BASE + 32'd4;
        tick();
        tick();
        rst     = 1'b1;
        ld_we   = 1'b1;
        ld_addr = 10'd5;
        ld_data = 32'hBAD0_BAD0;
        tick();
        rst   = 1'b0;
        ld_we = 1'b0;
        stb3  = 1'b0;
        checks++;
        if (inst3 !== NOP) begin
            errors++;
            $display("FAIL rst_inst got=%h exp=%h", inst3, NOP);
        end
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            seen = seen | ack3;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_noack got ack_seen=%b exp=0", seen);
        end

        // Next strobe served normally; word 5 keeps its pre-reset value.
        stb3  = 1'b1;
        addr3 = BASE + 32'd20;
        seen  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            seen = seen | ack3;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_early got ack_seen=%b exp=0", seen);
        end
        tick();
        checks++;
        if (ack3 !== 1'b1 || inst3 !== WORD5) begin
            errors++;
            $display("FAIL post_rst_fetch got ack=%b inst=%h exp ack=1 inst=%h", ack3, inst3, WORD5);
        end
        stb3 = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        ld_we   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        stb0 = 1'b0; stb1 = 1'b0; stb3 = 1'b0;
        addr0 = '0;  addr1 = '0;  addr3 = '0;
        test_reset();
        load_program();
        test_ws1_latency();
        test_ws0_stream();
        test_redirect();
        test_fault();
        test_forward();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
